// File: rtl/uno_horner_apply.sv
// uno_horner_apply
//
// Consumer of the PE scale generator. For exp/div/log ops it evaluates a
// fixed-order Horner polynomial on the fractional part of x, one MAC per cycle,
// and then combines the result with the registered scale word. gemm ops do a
// single x*y multiply. Only one operation is in flight at a time.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   gemm_uno   op code: 00 gemm, 01 div, 10 exp, 11 log
//   x_i, y_i   signed Q(INT_BW).(FRA_BW) operands (shared with the scale generator)
//   in_valid   input bus valid
//   in_ready   high in IDLE only
//   scale_i    registered scale word, sampled the cycle after accept
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   result_o   signed saturated result
//   sat_o      sticky saturation flag for the current op
//
// Build option:
//   UNO_HORNER_ROUND_EN  when defined, every >> FRA_BW rounds half up instead of
//                        truncating toward -inf.

module uno_horner_apply #(
    parameter int unsigned INT_BW = 5,
    parameter int unsigned FRA_BW = 10,
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned ORDER  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        gemm_uno,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] y_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_BW-1:0] scale_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MUL_BW-1:0] result_o,
    output logic              sat_o
);

    if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_bad_width
        $error("MUL_BW must equal 1 + INT_BW + FRA_BW");
    end
    if (ORDER < 1 || ORDER > 4) begin : g_bad_order
        $error("ORDER must be in 1..4");
    end

    // One extra bit above the full product leaves room for the rounding add.
    localparam int unsigned PW = 2 * MUL_BW + 1;

    localparam logic [1:0] OpGemm = 2'b00;
    localparam logic [1:0] OpDiv  = 2'b01;
    localparam logic [1:0] OpExp  = 2'b10;
    localparam logic [1:0] OpLog  = 2'b11;

    localparam logic signed [PW-1:0] SatMax = {{(PW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
    localparam logic signed [PW-1:0] SatMin = {{(PW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StWait, StHorner, StFinal, StDone} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic signed [MUL_BW-1:0] x_q, x_d;
    logic signed [MUL_BW-1:0] y_q, y_d;
    logic signed [MUL_BW-1:0] scale_q, scale_d;
    logic signed [MUL_BW-1:0] acc_q, acc_d;
    logic signed [MUL_BW-1:0] result_q, result_d;
    logic [2:0]               k_q, k_d;
    logic                     sat_q, sat_d;

    // Q5.10 coefficient tables; gemm has none and reads as zero.
    function automatic logic signed [MUL_BW-1:0] coef(input logic [1:0] op,
                                                      input logic [2:0] idx);
        logic signed [MUL_BW-1:0] c;
        c = '0;
        case (op)
            OpExp: begin
                case (idx)
                    3'd0:    c = MUL_BW'(1024);
                    3'd1:    c = MUL_BW'(1024);
                    3'd2:    c = MUL_BW'(512);
                    3'd3:    c = MUL_BW'(171);
                    3'd4:    c = MUL_BW'(43);
                    default: c = '0;
                endcase
            end
            OpDiv: begin
                case (idx)
                    3'd0:    c = MUL_BW'(1024);
                    3'd1:    c = MUL_BW'(-1024);
                    3'd2:    c = MUL_BW'(1024);
                    3'd3:    c = MUL_BW'(-1024);
                    3'd4:    c = MUL_BW'(1024);
                    default: c = '0;
                endcase
            end
            OpLog: begin
                case (idx)
                    3'd0:    c = MUL_BW'(0);
                    3'd1:    c = MUL_BW'(1024);
                    3'd2:    c = MUL_BW'(-512);
                    3'd3:    c = MUL_BW'(341);
                    3'd4:    c = MUL_BW'(-256);
                    default: c = '0;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic signed [PW-1:0] sext(input logic signed [MUL_BW-1:0] v);
        return {{(PW-MUL_BW){v[MUL_BW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] shr_frac(input logic signed [2*MUL_BW-1:0] p);
        logic signed [PW-1:0] w;
        w = {p[2*MUL_BW-1], p};
`ifdef UNO_HORNER_ROUND_EN
        w = w + (PW'(1) << (FRA_BW - 1));
`else
        w = w;
`endif
        return w >>> FRA_BW;
    endfunction

    // Returns {overflow, clamped value}.
    function automatic logic [MUL_BW:0] sat_w(input logic signed [PW-1:0] v);
        if (v > SatMax) begin
            return {1'b1, SatMax[MUL_BW-1:0]};
        end else if (v < SatMin) begin
            return {1'b1, SatMin[MUL_BW-1:0]};
        end
        return {1'b0, v[MUL_BW-1:0]};
    endfunction

    logic signed [MUL_BW-1:0]   f_ext;
    logic signed [MUL_BW-1:0]   mul_a, mul_b;
    logic signed [2*MUL_BW-1:0] mul_p;
    logic [MUL_BW:0]            prod_sat, step_sat, fin_sat;

    // Fraction of x, zero-extended so it is always in [0, 1).
    assign f_ext = {{(MUL_BW-FRA_BW){1'b0}}, x_q[FRA_BW-1:0]};

    // A single multiplier serves both the Horner steps and the final combine.
    always_comb begin
        mul_a = acc_q;
        mul_b = scale_q;
        if (state_q == StHorner) begin
            mul_b = f_ext;
        end else if (op_q == OpGemm) begin
            mul_a = x_q;
            mul_b = y_q;
        end
    end

    assign mul_p    = mul_a * mul_b;
    assign prod_sat = sat_w(shr_frac(mul_p));
    assign step_sat = sat_w(sext(prod_sat[MUL_BW-1:0]) + sext(coef(op_q, k_q)));
    assign fin_sat  = (op_q == OpLog) ? sat_w(sext(acc_q) + sext(scale_q)) : prod_sat;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        scale_d  = scale_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        sat_d    = sat_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = gemm_uno;
                    x_d     = x_i;
                    y_d     = y_i;
                    acc_d   = coef(gemm_uno, 3'(ORDER));
                    sat_d   = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                scale_d = scale_i;
                if (op_q == OpGemm) begin
                    state_d = StFinal;
                end else begin
                    k_d     = 3'(ORDER - 1);
                    state_d = StHorner;
                end
            end
            StHorner: begin
                acc_d = step_sat[MUL_BW-1:0];
                sat_d = sat_q | prod_sat[MUL_BW] | step_sat[MUL_BW];
                if (k_q == '0) begin
                    state_d = StFinal;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            StFinal: begin
                result_d = fin_sat[MUL_BW-1:0];
                sat_d    = sat_q | fin_sat[MUL_BW];
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            scale_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            scale_q  <= scale_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            sat_q    <= sat_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result_o  = result_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_uno_horner_apply.sv
// Testbench for uno_horner_apply: scoreboard of expected results pushed at
// accept and compared on each output handshake, plus directed checks of reset,
// backpressure, mid-op reset and accept spacing.

module tb_uno_horner_apply;

    localparam int ORDER = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gemm_uno;
    logic [15:0] x_i, y_i, scale_i;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [15:0] result_o;
    logic        sat_o;

    uno_horner_apply dut (
        .clk       (clk),
        .rst       (rst),
        .gemm_uno  (gemm_uno),
        .x_i       (x_i),
        .y_i       (y_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scale_i   (scale_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .sat_o     (sat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          vcyc;
    } exp_t;
    exp_t sb[$];

    logic ov_prev = 1'b0;
    int   last_acc = -1;
    bit   last_gemm = 1'b0;
    bit   chk_spacing = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met within bound", tag);
    endtask

    function automatic longint clip(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit ovf(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference arithmetic in plain integers.
    task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] s, output logic [15:0] res, output logic sat);
        longint c[5];
        longint acc, f, t, xs, ys, ss;
        case (op)
            2'b10:   c = '{1024, 1024, 512, 171, 43};
            2'b01:   c = '{1024, -1024, 1024, -1024, 1024};
            2'b11:   c = '{0, 1024, -512, 341, -256};
            default: c = '{0, 0, 0, 0, 0};
        endcase
        sat = 1'b0;
        f   = longint'({6'd0, x[9:0]});
        acc = c[ORDER];
        for (int k = ORDER - 1; k >= 0; k--) begin
            t   = (acc * f) >>> 10;
            sat = sat | ovf(t);
            t   = clip(t) + c[k];
            sat = sat | ovf(t);
            acc = clip(t);
        end
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        ss = longint'($signed(s));
        case (op)
            2'b00:   t = (xs * ys) >>> 10;
            2'b11:   t = acc + ss;
            default: t = (acc * ss) >>> 10;
        endcase
        sat = sat | ovf(t);
        t   = clip(t);
        res = t[15:0];
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge
    // that ends the WAIT cycle.
    task automatic send(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] s, input logic [15:0] er, input logic es);
        int   n;
        exp_t e;
        gemm_uno = op;
        x_i      = x;
        y_i      = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_wait");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (chk_spacing && last_acc >= 0) begin
            check_eq("accept_spacing", cyc - last_acc, last_gemm ? 4 : 4 + ORDER);
        end
        last_acc  = cyc;
        last_gemm = (op == 2'b00);
        e.res  = er;
        e.sat  = es;
        e.vcyc = cyc + 2 + ((op == 2'b00) ? 0 : ORDER);
        sb.push_back(e);
        in_valid = 1'b0;
        x_i      = 16'hDEAD;
        y_i      = 16'hBEEF;
        scale_i  = s;
        @(posedge clk); #1;
        scale_i  = 16'hA5A5;
    endtask

    task automatic send_m(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] s);
        logic [15:0] er;
        logic        es;
        model(op, x, y, s, er, es);
        send(op, x, y, s, er, es);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) fail_now("drain");
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) fail_now("spurious_out_valid");
                else check_eq("latency", cyc, sb[0].vcyc);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                check_eq("result", result_o, sb[0].res);
                check_eq("sat", sat_o, sb[0].sat);
                void'(sb.pop_front());
            end
            ov_prev <= out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] er;
        logic        es;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        gemm_uno  = 2'b00;
        x_i       = '0;
        y_i       = '0;
        scale_i   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result_o, 0);
        check_eq("rst_sat", sat_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed values from hand calculation.
        send(2'b10, 16'h0200, 16'h0000, 16'h1000, 16'h1A60, 1'b0);
        send(2'b01, 16'h0400, 16'h0000, 16'h0800, 16'h0800, 1'b0);
        send(2'b11, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
        send(2'b00, 16'h0800, 16'h0C00, 16'h0000, 16'h1800, 1'b0);
        send(2'b00, 16'h7C00, 16'h0800, 16'h0000, 16'h7FFF, 1'b1);
        wait_idle();

        // Backpressure in DONE.
        out_ready = 1'b0;
        model(2'b10, 16'h0155, 16'h0000, 16'h0C00, er, es);
        send(2'b10, 16'h0155, 16'h0000, 16'h0C00, er, es);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail_now("bp_out_valid_wait");
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_result_stable", result_o, er);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
            in_valid = 1'b1;
            gemm_uno = 2'b00;
            x_i      = 16'h1234;
            y_i      = 16'h4321;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_in_ready", in_ready, 1);
        check_eq("bp_release_out_valid", out_valid, 0);

        // Reset during HORNER aborts the op.
        send_m(2'b10, 16'h03FF, 16'h0000, 16'h1000);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_result", result_o, 0);
        check_eq("midrst_sat", sat_o, 0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        send(2'b10, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 1'b0);
        wait_idle();

        // Back-to-back stream with out_ready held high.
        chk_spacing = 1'b1;
        last_acc    = -1;
        send_m(2'b10, 16'h03FF, 16'h0000, 16'h7FFF);
        send_m(2'b11, 16'h0300, 16'h0000, 16'h7F00);
        send_m(2'b01, 16'h8123, 16'h0000, 16'hC000);
        for (int i = 0; i < 14; i++) begin
            send_m(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        wait_idle();
        chk_spacing = 1'b0;

        check_eq("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
